// File: rtl/synth_pkg.sv
// Shared constants, FSM state encoding and sizing helper for the soundgen
// wavetable request path.
package synth_pkg;

  localparam int PHASE_W_DEF = 24;
  localparam int WT_ADDR_W   = 10;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ISSUE_R,
    WAIT_R,
    ISSUE_L,
    WAIT_L,
    ADV
  } state_t;

  function automatic int unsigned vidx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wavetable_addr_gen_if.sv
// Wavetable request bundle from wavetable_addr_gen (master) to soundgen (slave).
interface wavetable_addr_gen_if
  import synth_pkg::*;
#(
  parameter int NVOICES = 8
);
  localparam int VW = int'(vidx_w(NVOICES));

  logic [WT_ADDR_W-1:0] wavetable_r;
  logic                 wavetable_r_valid;
  logic [WT_ADDR_W-1:0] wavetable_l;
  logic                 wavetable_l_valid;
  logic [VW-1:0]        voice_idx;

  modport master (
    output wavetable_r, wavetable_r_valid, wavetable_l, wavetable_l_valid, voice_idx
  );

  modport slave (
    input wavetable_r, wavetable_r_valid, wavetable_l, wavetable_l_valid, voice_idx
  );

endinterface

// File: rtl/voice_phase_regs.sv
// Per-voice increment/gate/phase storage with a programming write port and
// a read-modify-write accumulate port.
module voice_phase_regs
  import synth_pkg::*;
#(
  parameter int  NVOICES = 8,
  parameter int  PHASE_W = PHASE_W_DEF,
  localparam int VW      = int'(vidx_w(NVOICES))
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [VW-1:0]        wr_sel,
  input  logic [PHASE_W-1:0]   wr_inc,
  input  logic                 wr_gate,
  input  logic [VW-1:0]        rd_sel,
  input  logic                 adv_en,
  output logic [WT_ADDR_W-1:0] rd_addr,
  output logic                 rd_gate
);

  logic [PHASE_W-1:0] phase_q [NVOICES];
  logic [PHASE_W-1:0] inc_q   [NVOICES];
  logic [NVOICES-1:0] gate_q;

  assign rd_addr = phase_q[rd_sel][PHASE_W-1 -: WT_ADDR_W];
  assign rd_gate = gate_q[rd_sel];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NVOICES; i++) begin
        phase_q[i] <= '0;
        inc_q[i]   <= '0;
      end
      gate_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NVOICES; i++) begin
        if (wr_en && wr_sel == VW'(i)) begin
          inc_q[i]  <= wr_inc;
          gate_q[i] <= wr_gate;
        end
        // Note-on reset of the phase takes priority over a same-cycle accumulate.
        if (wr_en && wr_gate && wr_sel == VW'(i)) begin
          phase_q[i] <= '0;
        end else if (adv_en && gate_q[i] && rd_sel == VW'(i)) begin
          phase_q[i] <= phase_q[i] + inc_q[i];
        end
      end
    end
  end

endmodule

// File: rtl/wavetable_addr_gen.sv
// Per-frame voice scanner issuing paired right/left wavetable address strobes
// to soundgen, spaced by GAP idle cycles.
module wavetable_addr_gen
  import synth_pkg::*;
#(
  parameter int                   NVOICES  = 8,
  parameter int                   PHASE_W  = PHASE_W_DEF,
  parameter int                   GAP      = 3,
  parameter logic [WT_ADDR_W-1:0] L_OFFSET = 10'd0,
  localparam int                  VW       = int'(vidx_w(NVOICES))
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick48k,
  input  logic                 voice_wr,
  input  logic [VW-1:0]        voice_sel,
  input  logic [PHASE_W-1:0]   voice_inc,
  input  logic                 voice_gate,
  wavetable_addr_gen_if.master wt,
  output logic                 busy,
  output logic                 overrun
);

  localparam int GW = $clog2(GAP + 1);

  state_t               state_q, state_d;
  logic [VW-1:0]        v_q, v_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [WT_ADDR_W-1:0] r_last_q, l_last_q;
  logic                 overrun_q;
  logic                 adv_en;
  logic [WT_ADDR_W-1:0] cur_addr, l_addr;
  logic                 cur_gate;

  voice_phase_regs #(
    .NVOICES (NVOICES),
    .PHASE_W (PHASE_W)
  ) u_regs (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (voice_wr),
    .wr_sel  (voice_sel),
    .wr_inc  (voice_inc),
    .wr_gate (voice_gate),
    .rd_sel  (v_q),
    .adv_en  (adv_en),
    .rd_addr (cur_addr),
    .rd_gate (cur_gate)
  );

  assign l_addr = cur_addr + L_OFFSET;

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    gap_d   = gap_q;
    adv_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick48k) begin
          state_d = CHECK;
          v_d     = '0;
        end
      end
      CHECK:   state_d = cur_gate ? ISSUE_R : ADV;
      ISSUE_R: begin
        state_d = WAIT_R;
        gap_d   = GW'(GAP - 1);
      end
      WAIT_R: begin
        if (gap_q == '0) state_d = ISSUE_L;
        else             gap_d   = gap_q - 1'b1;
      end
      ISSUE_L: begin
        state_d = WAIT_L;
        gap_d   = GW'(GAP - 1);
      end
      WAIT_L: begin
        if (gap_q == '0) state_d = ADV;
        else             gap_d   = gap_q - 1'b1;
      end
      ADV: begin
        adv_en = 1'b1;
        if (v_q == VW'(NVOICES - 1)) begin
          state_d = IDLE;
        end else begin
          state_d = CHECK;
          v_d     = v_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      v_q       <= '0;
      gap_q     <= '0;
      r_last_q  <= '0;
      l_last_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      v_q       <= v_d;
      gap_q     <= gap_d;
      overrun_q <= tick48k && (state_q != IDLE);
      if (state_q == ISSUE_R) r_last_q <= cur_addr;
      if (state_q == ISSUE_L) l_last_q <= l_addr;
    end
  end

  // Addresses are driven live from the phase registers in the issue cycle so
  // a same-cycle register update is honoured; otherwise the last value holds.
  assign wt.wavetable_r_valid = (state_q == ISSUE_R);
  assign wt.wavetable_l_valid = (state_q == ISSUE_L);
  assign wt.wavetable_r       = (state_q == ISSUE_R) ? cur_addr : r_last_q;
  assign wt.wavetable_l       = (state_q == ISSUE_L) ? l_addr : l_last_q;
  assign wt.voice_idx         = v_q;
  assign busy                 = (state_q != IDLE);
  assign overrun              = overrun_q;

endmodule

// File: tb/tb_wavetable_addr_gen.sv
// Scoreboard bench: two instances (L_OFFSET 0 and 512) share stimulus; a
// negedge monitor pops expected strobes (kind, address, voice, cycle).
module tb_wavetable_addr_gen;

  localparam int GAP = 3;

  typedef struct {
    bit         is_l;
    logic [9:0] addr;
    int         idx;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick48k;
  logic        voice_wr;
  logic [2:0]  voice_sel;
  logic [23:0] voice_inc;
  logic        voice_gate;
  logic        busy_a, ovr_a, busy_b, ovr_b;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   ovr_cnt = 0;
  int   ovr_last = -1;
  exp_t q0[$];
  exp_t q1[$];

  wavetable_addr_gen_if #(.NVOICES(8)) wa ();
  wavetable_addr_gen_if #(.NVOICES(8)) wb ();

  wavetable_addr_gen #(
    .NVOICES  (8),
    .PHASE_W  (24),
    .GAP      (GAP),
    .L_OFFSET (10'd0)
  ) dut_a (
    .clk        (clk),
    .rst        (rst),
    .tick48k    (tick48k),
    .voice_wr   (voice_wr),
    .voice_sel  (voice_sel),
    .voice_inc  (voice_inc),
    .voice_gate (voice_gate),
    .wt         (wa),
    .busy       (busy_a),
    .overrun    (ovr_a)
  );

  wavetable_addr_gen #(
    .NVOICES  (8),
    .PHASE_W  (24),
    .GAP      (GAP),
    .L_OFFSET (10'd512)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .tick48k    (tick48k),
    .voice_wr   (voice_wr),
    .voice_sel  (voice_sel),
    .voice_inc  (voice_inc),
    .voice_gate (voice_gate),
    .wt         (wb),
    .busy       (busy_b),
    .overrun    (ovr_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input int k, input logic rv, input logic lv,
                     input logic [9:0] r, input logic [9:0] l, input logic [2:0] idx);
    exp_t e;
    string tg;
    tg = (k == 0) ? "a" : "b";
    if (rv || lv) begin
      chk({tg, "_rl_exclusive"}, int'(rv & lv), 0);
      if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL %s_unexpected_strobe actual=r%0d/l%0d required=none (cycle %0d)",
                 tg, rv, lv, cyc);
      end else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        chk({tg, "_kind_is_l"}, int'(lv), int'(e.is_l));
        chk({tg, "_addr"}, int'(e.is_l ? l : r), int'(e.addr));
        chk({tg, "_voice_idx"}, int'(idx), e.idx);
        chk({tg, "_strobe_cycle"}, cyc, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, wa.wavetable_r_valid, wa.wavetable_l_valid, wa.wavetable_r, wa.wavetable_l, wa.voice_idx);
    mon(1, wb.wavetable_r_valid, wb.wavetable_l_valid, wb.wavetable_r, wb.wavetable_l, wb.voice_idx);
    if (ovr_a) begin
      ovr_cnt++;
      ovr_last = cyc;
    end
  end

  function automatic logic [79:0] va(input int v, input logic [9:0] a);
    return 80'(a) << (v * 10);
  endfunction

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic prog(input logic [2:0] sel, input logic [23:0] inc, input logic gate);
    @(posedge clk);
    #1;
    voice_wr   = 1'b1;
    voice_sel  = sel;
    voice_inc  = inc;
    voice_gate = gate;
    @(posedge clk);
    #1;
    voice_wr = 1'b0;
  endtask

  // Pulses tick48k and queues the strobes of one frame; ra holds hand-computed
  // right addresses per active voice. tend is the first idle cycle after it.
  task automatic frame(input logic [7:0] act, input logic [79:0] ra,
                       output int t0, output int tend);
    int t;
    logic [9:0] a;
    @(posedge clk);
    #1;
    t0      = cyc;
    tick48k = 1'b1;
    t       = t0 + 1;
    for (int v = 0; v < 8; v++) begin
      if (act[v]) begin
        a = ra[v*10 +: 10];
        q0.push_back('{1'b0, a, v, t + 1});
        q1.push_back('{1'b0, a, v, t + 1});
        q0.push_back('{1'b1, a, v, t + 2 + GAP});
        q1.push_back('{1'b1, a + 10'd512, v, t + 2 + GAP});
        t += 2 * GAP + 4;
      end else begin
        t += 2;
      end
    end
    tend = t;
    @(posedge clk);
    #1;
    tick48k = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int t0, te, p;
    exp_t e;
    rst        = 1'b1;
    tick48k    = 1'b0;
    voice_wr   = 1'b0;
    voice_sel  = '0;
    voice_inc  = '0;
    voice_gate = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_r",       int'(wa.wavetable_r), 0);
    chk("rst_l",       int'(wa.wavetable_l), 0);
    chk("rst_r_valid", int'(wa.wavetable_r_valid), 0);
    chk("rst_l_valid", int'(wa.wavetable_l_valid), 0);
    chk("rst_idx",     int'(wa.voice_idx), 0);
    chk("rst_busy",    int'(busy_a), 0);
    chk("rst_overrun", int'(ovr_a), 0);
    rst = 1'b0;
    goto(cyc + 2);

    // Basic stepping: address advances by one per frame.
    prog(3'd0, 24'h004000, 1'b1);
    frame(8'h01, va(0, 10'd0), t0, te);  goto(te + 3);
    frame(8'h01, va(0, 10'd1), t0, te);  goto(te + 3);
    frame(8'h01, va(0, 10'd2), t0, te);  goto(te + 3);
    chk("hold_r", int'(wa.wavetable_r), 2);
    chk("hold_l", int'(wa.wavetable_l), 2);

    // Left offset wrap: top bits 700 + 512 -> 188.
    prog(3'd0, 24'hAF0000, 1'b1);
    frame(8'h01, va(0, 10'd0),   t0, te);  goto(te + 3);
    frame(8'h01, va(0, 10'd700), t0, te);  goto(te + 3);
    chk("b_hold_l_wrap", int'(wb.wavetable_l), 188);

    // Accumulator wrap going backwards.
    prog(3'd0, 24'hFFC000, 1'b1);
    frame(8'h01, va(0, 10'd0),    t0, te);  goto(te + 3);
    frame(8'h01, va(0, 10'd1023), t0, te);  goto(te + 3);
    frame(8'h01, va(0, 10'd1022), t0, te);  goto(te + 3);
    chk("hold_r_wrap", int'(wa.wavetable_r), 1022);
    prog(3'd0, 24'h000000, 1'b0);

    // Voices 1 and 5, busy envelope, overrun on a mid-frame tick.
    prog(3'd1, 24'h004000, 1'b1);
    prog(3'd5, 24'h008000, 1'b1);
    frame(8'h22, va(1, 10'd0) | va(5, 10'd0), t0, te);  goto(te + 3);
    frame(8'h22, va(1, 10'd1) | va(5, 10'd2), t0, te);
    chk("busy_start", int'(busy_a), 1);
    goto(t0 + 4);
    p       = cyc;
    tick48k = 1'b1;
    @(posedge clk);
    #1;
    tick48k = 1'b0;
    goto(p + 3);
    chk("overrun_count", ovr_cnt, 1);
    chk("overrun_cycle", ovr_last, p + 1);
    goto(te - 1);
    chk("busy_last_adv", int'(busy_a), 1);
    goto(te);
    chk("busy_drop", int'(busy_a), 0);
    goto(te + 3);
    prog(3'd1, 24'h000000, 1'b0);
    prog(3'd5, 24'h000000, 1'b0);

    // Note-on for voice 3 landing in its ADV cycle (frame start + 16).
    prog(3'd3, 24'h004000, 1'b1);
    frame(8'h08, va(3, 10'd0), t0, te);  goto(te + 3);
    frame(8'h08, va(3, 10'd1), t0, te);
    goto(t0 + 16);
    voice_wr   = 1'b1;
    voice_sel  = 3'd3;
    voice_inc  = 24'h004000;
    voice_gate = 1'b1;
    @(posedge clk);
    #1;
    voice_wr = 1'b0;
    goto(te + 3);
    frame(8'h08, va(3, 10'd0), t0, te);  goto(te + 3);

    // Asynchronous reset during WAIT_R of voice 3: only the R strobe is expected.
    @(posedge clk);
    #1;
    t0      = cyc;
    tick48k = 1'b1;
    e       = '{1'b0, 10'd1, 3, t0 + 8};
    q0.push_back(e);
    q1.push_back(e);
    @(posedge clk);
    #1;
    tick48k = 1'b0;
    goto(t0 + 10);
    rst = 1'b1;
    #1;
    chk("mid_rst_r",       int'(wa.wavetable_r), 0);
    chk("mid_rst_l",       int'(wa.wavetable_l), 0);
    chk("mid_rst_r_valid", int'(wa.wavetable_r_valid), 0);
    chk("mid_rst_idx",     int'(wa.voice_idx), 0);
    chk("mid_rst_busy",    int'(busy_a), 0);
    chk("mid_rst_b_l",     int'(wb.wavetable_l), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    goto(cyc + 40);

    chk("a_queue_empty", q0.size(), 0);
    chk("b_queue_empty", q1.size(), 0);
    chk("overrun_total", ovr_cnt, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
